prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Host-side writer for the core's byte-wide instruction-memory load port: drives inst_address/inst_data/inst_we.
- Accepts a framed byte stream (header, length, payload, checksum) over a valid/ready handshake and writes payload bytes to sequential addresses from 0.
- Holds the core in reset (cpu_hold) from reset until a frame completes with a good checksum.
- Sits between the external host interface (UART/SPI byte receiver) and the core top level.

Parameters:
- DEPTH, 128, instruction-memory depth in bytes; maximum legal frame length.
- ADDR_W, 7, address width; DEPTH <= 2**ADDR_W.
- HEADER, 8'hA5, frame start byte.
- TIMEOUT, 1024, maximum idle cycles between accepted bytes inside a frame; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-high reset.
- in_data  in  8  host byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader can accept a byte; a byte is accepted on a rising edge with in_valid & in_ready.
- inst_address  out  ADDR_W  write address to instruction memory.
- inst_data  out  8  write data to instruction memory.
- inst_we  out  1  one-cycle write strobe.
- cpu_hold  out  1  high keeps the core in reset.
- load_done  out  1  last frame completed with a good checksum; sticky.
- load_error  out  1  last frame failed; sticky.

Behaviour:
- Reset (async, clr=1):
  - state=IDLE, in_ready=1, inst_we=0, inst_address=0, inst_data=0.
  - cpu_hold=1, load_done=0, load_error=0.
  - Internal: idx=0, len=0, sum=0, timer=0.
- All outputs are registered.
- IDLE:
  - in_ready=1.
  - Accepted byte == HEADER -> LEN; set cpu_hold=1, clear load_done and load_error, idx=0, sum=0.
  - Any other byte is discarded; stay in IDLE.
- LEN:
  - in_ready=1. Accepted byte L:
  - L==0 or L>DEPTH -> ERR.
  - Otherwise len=L -> DATA.
- DATA:
  - in_ready=1. Accepted byte B: capture inst_data=B, inst_address=idx[ADDR_W-1:0], sum=sum+B (mod 256) -> WRITE.
- WRITE (exactly one cycle):
  - inst_we=1 and in_ready=0; the host must hold or withhold its byte.
  - idx=idx+1.
  - If idx+1==len -> CHECK, else -> DATA.
  - inst_we is 0 in every other state.
- CHECK:
  - in_ready=1. Accepted byte C:
  - C==sum -> DONE: cpu_hold=0, load_done=1.
  - Otherwise -> ERR: load_error=1, cpu_hold stays 1.
- DONE / ERR:
  - Behave as IDLE for header detection, so a new frame can restart from either state.
  - Non-header bytes are ignored; flags keep their values.
- Timeout:
  - timer clears on every accepted byte and in IDLE/DONE/ERR.
  - In LEN/DATA/CHECK the timer increments each cycle.
  - timer reaching TIMEOUT -> ERR with load_error=1.
- Throughput: 1 byte per cycle in LEN/CHECK; 1 payload byte per 2 cycles.
- Write latency: inst_we is asserted the cycle after the accepting edge.
- Address wrap: none, because len<=DEPTH; idx never exceeds DEPTH-1 on a write.
- Aborted frame: bytes already written stay in memory and are not rolled back; cpu_hold remains 1.
- Reset mid-frame: returns to IDLE, cpu_hold=1, and any in-progress inst_we is dropped immediately.
- A HEADER value inside the payload is treated as data; only IDLE/DONE/ERR detect headers.

Test Plan:
- Good frame: A5, 03, 13, 00, 50, checksum 63 -> three inst_we pulses (addr0=13, addr1=00, addr2=50); in_ready low during each pulse; then load_done=1, cpu_hold=0.
- Bad checksum: A5, 02, 11, 22, 00 -> two writes, then load_error=1, cpu_hold=1, load_done=0; a following good frame clears load_error and sets load_done.
- Illegal length: A5, 00 -> ERR with no inst_we pulse. Separately, A5, 81 (129 > DEPTH) -> ERR.
- Timeout: A5, 04, 01, then in_valid low for 1024 cycles -> load_error=1; one write only at addr 0.
- Full depth with backpressure: 128-byte payload with in_valid held high throughout -> writes to addresses 0..127 exactly once each, no skipped or duplicated bytes; checksum OK -> load_done.
- Reset and noise: clr asserted mid-payload -> all outputs at reset values asynchronously, inst_we=0 same cycle. Non-A5 bytes sent in IDLE -> no state change.

Source files
------------

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
// Host-side writer for the core's byte-wide instruction-memory load port.
// Receives a framed byte stream (HEADER, length, payload, checksum) over a
// valid/ready handshake and writes payload bytes to sequential addresses
// starting at 0. The core is held in reset (cpu_hold) until a frame finishes
// with a matching checksum.
//
// Ports:
//   clk          in   system clock, rising edge
//   clr          in   asynchronous active-high reset
//   in_data      in   host byte
//   in_valid     in   in_data valid
//   in_ready     out  loader can accept a byte (accept = in_valid & in_ready)
//   inst_address out  instruction-memory write address
//   inst_data    out  instruction-memory write data
//   inst_we      out  one-cycle write strobe
//   cpu_hold     out  high keeps the core in reset
//   load_done    out  last frame completed with a good checksum (sticky)
//   load_error   out  last frame failed (sticky)
// ---------------------------------------------------------------------------
module prog_loader #(
   parameter int         DEPTH   = 128,
   parameter int         ADDR_W  = 7,
   parameter logic [7:0] HEADER  = 8'hA5,
   parameter int         TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] inst_address,
   output logic [7:0]        inst_data,
   output logic              inst_we,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_error
);

   // idx and len must be able to hold the value DEPTH itself
   localparam int IW = $clog2(DEPTH + 1);
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [8:0]    DEPTH9    = 9'(DEPTH);
   localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      DATA,
      WRITE,
      CHECK,
      DONE,
      ERR
   } state_t;

   state_t            state_q, state_d;
   logic              inReady_q, inReady_d;
   logic [ADDR_W-1:0] instAddress_q, instAddress_d;
   logic [7:0]        instData_q, instData_d;
   logic              instWe_q, instWe_d;
   logic              cpuHold_q, cpuHold_d;
   logic              loadDone_q, loadDone_d;
   logic              loadError_q, loadError_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [IW-1:0]     len_q, len_d;
   logic [7:0]        sum_q, sum_d;
   logic [TW-1:0]     timer_q, timer_d;

   logic accept;
   logic inFrame;

   assign accept  = in_valid & inReady_q;
   assign inFrame = (state_q == LEN) || (state_q == DATA) || (state_q == CHECK);

   // Next-state logic. in_ready and inst_we are derived from the next state so
   // that both are registered yet line up exactly with the WRITE cycle. The
   // timeout override at the end only fires in a byte-waiting state with no
   // byte accepted, where nothing else would have changed.
   always_comb begin
      state_d       = state_q;
      instAddress_d = instAddress_q;
      instData_d    = instData_q;
      cpuHold_d     = cpuHold_q;
      loadDone_d    = loadDone_q;
      loadError_d   = loadError_q;
      idx_d         = idx_q;
      len_d         = len_q;
      sum_d         = sum_q;
      timer_d       = '0;

      case (state_q)
         IDLE, DONE, ERR: begin
            if (accept && (in_data == HEADER)) begin
               state_d     = LEN;
               cpuHold_d   = 1'b1;
               loadDone_d  = 1'b0;
               loadError_d = 1'b0;
               idx_d       = '0;
               sum_d       = '0;
            end
         end
         LEN: begin
            if (accept) begin
               if ((in_data == 8'd0) || ({1'b0, in_data} > DEPTH9)) begin
                  state_d     = ERR;
                  loadError_d = 1'b1;
               end else begin
                  len_d   = IW'(in_data);
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (accept) begin
               instData_d    = in_data;
               instAddress_d = idx_q[ADDR_W-1:0];
               sum_d         = sum_q + in_data;
               state_d       = WRITE;
            end
         end
         WRITE: begin
            idx_d   = idx_q + IW'(1);
            state_d = ((idx_q + IW'(1)) == len_q) ? CHECK : DATA;
         end
         CHECK: begin
            if (accept) begin
               if (in_data == sum_q) begin
                  state_d    = DONE;
                  cpuHold_d  = 1'b0;
                  loadDone_d = 1'b1;
               end else begin
                  state_d     = ERR;
                  loadError_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (inFrame && !accept && (TIMEOUT != 0)) begin
         if ((timer_q + TW'(1)) == TIMEOUT_T) begin
            state_d     = ERR;
            loadError_d = 1'b1;
            timer_d     = '0;
         end else begin
            timer_d = timer_q + TW'(1);
         end
      end

      inReady_d = (state_d != WRITE);
      instWe_d  = (state_d == WRITE);
   end

   // State and output registers; clr drops inst_we immediately.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q       <= IDLE;
         inReady_q     <= 1'b1;
         instAddress_q <= '0;
         instData_q    <= '0;
         instWe_q      <= 1'b0;
         cpuHold_q     <= 1'b1;
         loadDone_q    <= 1'b0;
         loadError_q   <= 1'b0;
         idx_q         <= '0;
         len_q         <= '0;
         sum_q         <= '0;
         timer_q       <= '0;
      end else begin
         state_q       <= state_d;
         inReady_q     <= inReady_d;
         instAddress_q <= instAddress_d;
         instData_q    <= instData_d;
         instWe_q      <= instWe_d;
         cpuHold_q     <= cpuHold_d;
         loadDone_q    <= loadDone_d;
         loadError_q   <= loadError_d;
         idx_q         <= idx_d;
         len_q         <= len_d;
         sum_q         <= sum_d;
         timer_q       <= timer_d;
      end
   end

   assign in_ready     = inReady_q;
   assign inst_address = instAddress_q;
   assign inst_data    = instData_q;
   assign inst_we      = instWe_q;
   assign cpu_hold     = cpuHold_q;
   assign load_done    = loadDone_q;
   assign load_error   = loadError_q;

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
// Directed frames drive prog_loader; every expected instruction-memory write
// is queued when its payload byte is sent, and a negedge monitor pops and
// compares each inst_we pulse. Status flags are checked after each frame.
// ---------------------------------------------------------------------------
module tb_prog_loader;

   localparam int ADDR_W = 7;

   logic              clk = 1'b0;
   logic              clr;
   logic [7:0]        inData;
   logic              inValid;
   logic              inReady;
   logic [ADDR_W-1:0] instAddress;
   logic [7:0]        instData;
   logic              instWe;
   logic              cpuHold;
   logic              loadDone;
   logic              loadError;

   int checkCount = 0;
   int passCount  = 0;
   int nextAddr   = 0;
   logic [14:0] expQ[$];

   prog_loader #(
      .DEPTH(128),
      .ADDR_W(ADDR_W),
      .HEADER(8'hA5),
      .TIMEOUT(1024)
   ) dut (
      .clk(clk),
      .clr(clr),
      .in_data(inData),
      .in_valid(inValid),
      .in_ready(inReady),
      .inst_address(instAddress),
      .inst_data(instData),
      .inst_we(instWe),
      .cpu_hold(cpuHold),
      .load_done(loadDone),
      .load_error(loadError)
   );

   always #5 clk = ~clk;

   // Single comparison point shared by the monitor and the directed checks
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
   endtask

   // Write monitor: each strobe must match the oldest queued write
   always @(negedge clk) begin
      if (instWe === 1'b1) begin
         checkOutput("in_ready low during write", {31'd0, inReady}, 32'd0);
         if (expQ.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL unexpected write: addr %0h data %0h, expected no write",
                     instAddress, instData);
         end else begin
            logic [14:0] e;
            e = expQ.pop_front();
            checkOutput("write addr/data", {17'd0, instAddress, instData}, {17'd0, e});
         end
      end
   end

   // Offer one byte and hold it until the loader accepts it (bounded)
   task automatic applyStimulus(input logic [7:0] b);
      bit accepted = 0;
      inData  = b;
      inValid = 1'b1;
      for (int c = 0; c < 20 && !accepted; c++) begin
         @(negedge clk);
         if (inReady) begin
            @(posedge clk);
            accepted = 1;
         end
      end
      #1;
      if (!accepted) begin
         checkCount++;
         $display("[TB] FAIL byte accept: byte %0h not accepted, expected accept", b);
      end
   endtask

   task automatic sendData(input logic [7:0] b);
      expQ.push_back({7'(nextAddr), b});
      nextAddr++;
      applyStimulus(b);
   endtask

   task automatic startFrame(input logic [7:0] len);
      nextAddr = 0;
      applyStimulus(8'hA5);
      applyStimulus(len);
   endtask

   task automatic idleBus(input int n);
      inValid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkFlags(input string name, input logic hold,
                             input logic done, input logic err);
      checkOutput({name, " cpu_hold"}, {31'd0, cpuHold}, {31'd0, hold});
      checkOutput({name, " load_done"}, {31'd0, loadDone}, {31'd0, done});
      checkOutput({name, " load_error"}, {31'd0, loadError}, {31'd0, err});
   endtask

   task automatic checkDrained(input string name);
      checkOutput({name, " writes drained"}, expQ.size(), 32'd0);
   endtask

   initial begin
      logic [7:0] fullSum;
      logic [7:0] b;
      int n;

      clr = 1'b1; inValid = 1'b0; inData = 8'h00;
      #1;
      checkOutput("reset in_ready", {31'd0, inReady}, 32'd1);
      checkOutput("reset inst_we", {31'd0, instWe}, 32'd0);
      checkOutput("reset inst_address", {25'd0, instAddress}, 32'd0);
      checkOutput("reset inst_data", {24'd0, instData}, 32'd0);
      checkFlags("reset", 1'b1, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1 clr = 1'b0;
      idleBus(2);

      // Noise in IDLE is discarded
      applyStimulus(8'h00);
      applyStimulus(8'h13);
      applyStimulus(8'hFF);
      idleBus(3);
      checkOutput("noise in_ready", {31'd0, inReady}, 32'd1);
      checkFlags("noise", 1'b1, 1'b0, 1'b0);

      // Good frame
      startFrame(8'h03);
      sendData(8'h13);
      sendData(8'h00);
      sendData(8'h50);
      applyStimulus(8'h63);
      idleBus(3);
      checkFlags("good frame", 1'b0, 1'b1, 1'b0);
      checkDrained("good frame");

      // Bad checksum, then a good frame recovers
      startFrame(8'h02);
      sendData(8'h11);
      sendData(8'h22);
      applyStimulus(8'h00);
      idleBus(3);
      checkFlags("bad checksum", 1'b1, 1'b0, 1'b1);
      checkDrained("bad checksum");
      startFrame(8'h01);
      sendData(8'h7F);
      applyStimulus(8'h7F);
      idleBus(3);
      checkFlags("recovery frame", 1'b0, 1'b1, 1'b0);

      // Illegal lengths
      startFrame(8'h00);
      idleBus(3);
      checkFlags("length 0", 1'b1, 1'b0, 1'b1);
      startFrame(8'h81);
      idleBus(3);
      checkFlags("length 129", 1'b1, 1'b0, 1'b1);
      checkDrained("illegal length");

      // Timeout after one payload byte
      startFrame(8'h04);
      sendData(8'h01);
      inValid = 1'b0;
      n = 0;
      while (!loadError && n < 2000) begin
         @(posedge clk);
         n++;
      end
      #1;
      checkFlags("timeout", 1'b1, 1'b0, 1'b1);
      checkCount++;
      if (n >= 1020 && n <= 1030) passCount++;
      else $display("[TB] FAIL timeout latency: got %0d cycles, expected about 1025", n);
      checkDrained("timeout");

      // Full depth, in_valid held high across write cycles
      fullSum = 8'h00;
      startFrame(8'd128);
      for (int i = 0; i < 128; i++) begin
         b = 8'(i * 7 + 3);
         fullSum = fullSum + b;
         sendData(b);
      end
      applyStimulus(fullSum);
      idleBus(3);
      checkFlags("full depth", 1'b0, 1'b1, 1'b0);
      checkDrained("full depth");

      // Reset in the middle of a payload
      startFrame(8'h05);
      sendData(8'h01);
      applyStimulus(8'h02);
      clr = 1'b1;
      #1;
      checkOutput("mid reset inst_we", {31'd0, instWe}, 32'd0);
      checkOutput("mid reset in_ready", {31'd0, inReady}, 32'd1);
      checkOutput("mid reset inst_address", {25'd0, instAddress}, 32'd0);
      checkOutput("mid reset inst_data", {24'd0, instData}, 32'd0);
      checkFlags("mid reset", 1'b1, 1'b0, 1'b0);
      inValid = 1'b0;
      repeat (2) @(posedge clk);
      #1 clr = 1'b0;
      idleBus(3);
      checkDrained("mid reset");

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
